// File: rtl/wb_fabric_config_port_pkg.sv
// ============================================================================
// Module      : fabric_cfg_pkg
// Description : Shared constants, register map and drain FSM states for the
//               eFPGA configuration self-write port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fabric_cfg_pkg;

    localparam int DATA_W = 32;

    // Register offsets, selected by adr[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_WORDCNT = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_FULL   = 9;
    localparam int ST_EMPTY  = 10;
    localparam int ST_SELERR = 11;
    localparam int ST_DONE   = 12;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_GAP    = 2'd2
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_fabric_config_port_if.sv
// ============================================================================
// Module      : wb_fabric_config_port_if
// Description : Wishbone classic slave bus bundle for the config port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface wb_fabric_config_port_if
    import fabric_cfg_pkg::*;
();
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_fabric_config_port_fifo.sv
// ============================================================================
// Module      : cfg_fifo
// Description : Synchronous first-word-fall-through FIFO with flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cfg_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int             C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]  C_FULL = DEPTH[C_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (C_AW+1)'(1);
                2'b01:   r_count <= r_count - (C_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/wb_fabric_config_port.sv
// ============================================================================
// Module      : wb_fabric_config_port
// Description : Wishbone slave buffering config words and replaying them on
//               the eFPGA self-write strobe with programmable spacing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_fabric_config_port
    import fabric_cfg_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          STROBE_GAP = 1,
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK   = 32'hFFFF_FFF0
) (
    input  logic                   CLK,
    input  logic                   resetn,
    wb_fabric_config_port_if.slave wb,
    output logic                   SelfWriteStrobe,
    output logic [DATA_W-1:0]      SelfWriteData,
    output logic                   ComActive,
    output logic                   irq
);
    localparam int         C_CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] C_GAP_LAST = (STROBE_GAP > 0) ? 8'(STROBE_GAP - 1) : 8'd0;

    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [7:0]        r_gap_cnt;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_en;
    logic              r_irq_en;
    logic              r_flush_pend;
    logic              r_selerr;
    logic              r_done;
    logic [31:0]       r_wordcnt;
    logic [DATA_W-1:0] r_swdata;

    logic              w_match;
    logic              w_cycle;
    logic [1:0]        w_reg;
    logic              w_sel_ok;
    logic              w_data_wr;
    logic              w_stall;
    logic              w_accept;
    logic              w_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_can_pop;
    logic              w_finish;
    logic              w_done_set;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_fifo_dout;
    logic [C_CW-1:0]   w_count;
    logic              w_full;
    logic              w_empty;

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (resetn),
        .i_flush (r_flush_pend),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (wb.wbs_dat_i),
        .o_dout  (w_fifo_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_match   = ((wb.wbs_adr_i & ADR_MASK) == BASE_ADR);
    assign w_cycle   = wb.wbs_cyc_i & wb.wbs_stb_i & w_match;
    assign w_reg     = wb.wbs_adr_i[3:2];
    assign w_sel_ok  = (wb.wbs_sel_i == 4'hF);
    assign w_data_wr = wb.wbs_we_i & (w_reg == REG_DATA);
    // Only a well-formed DATA write waits for room; bad-sel writes ack at once
    assign w_stall   = w_data_wr & w_sel_ok & w_full & ~w_pop;
    assign w_accept  = w_cycle & ~r_ack & ~w_stall;
    assign w_wr      = w_accept & wb.wbs_we_i;
    assign w_push    = w_accept & w_data_wr & w_sel_ok;
    assign w_can_pop = r_en & ~w_empty & ~r_flush_pend;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CTRL: begin
                w_rdata[CTRL_EN]     = r_en;
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            REG_STATUS: begin
                w_rdata[C_CW-1:0]  = w_count;
                w_rdata[ST_FULL]   = w_full;
                w_rdata[ST_EMPTY]  = w_empty;
                w_rdata[ST_SELERR] = r_selerr;
                w_rdata[ST_DONE]   = r_done;
            end
            REG_WORDCNT: w_rdata = r_wordcnt;
            default:     w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_finish    = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (STROBE_GAP > 0) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_finish = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_finish = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Chain straight into the next strobe so the peak rate is 1/(GAP+1)
        if (w_finish) begin
            if (w_can_pop) begin
                w_pop       = 1'b1;
                w_state_nxt = S_STROBE;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_set  = w_empty & r_en;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 8'd0;
            r_swdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_STROBE) begin
                r_gap_cnt <= C_GAP_LAST;
            end else if (r_state == S_GAP && r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            if (w_pop) begin
                r_swdata <= w_fifo_dout;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_en         <= 1'b0;
            r_irq_en     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_selerr     <= 1'b0;
            r_done       <= 1'b0;
            r_wordcnt    <= '0;
        end else begin
            r_ack        <= w_accept;
            r_flush_pend <= w_wr & (w_reg == REG_CTRL) & wb.wbs_sel_i[0]
                            & wb.wbs_dat_i[CTRL_FLUSH];
            if (w_accept && !wb.wbs_we_i) begin
                r_rdata <= w_rdata;
            end
            if (w_wr && w_reg == REG_CTRL && wb.wbs_sel_i[0]) begin
                r_en     <= wb.wbs_dat_i[CTRL_EN];
                r_irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
            end
            // Clear first so a coincident new event is not lost
            if (w_wr && w_reg == REG_STATUS && wb.wbs_sel_i[0]) begin
                r_selerr <= 1'b0;
                r_done   <= 1'b0;
            end
            if (w_wr && w_data_wr && !w_sel_ok) begin
                r_selerr <= 1'b1;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end
            if (w_wr && w_reg == REG_WORDCNT) begin
                r_wordcnt <= '0;
            end else if (r_state == S_STROBE) begin
                r_wordcnt <= r_wordcnt + 32'd1;
            end
        end
    end

    assign wb.wbs_ack_o    = r_ack;
    assign wb.wbs_dat_o    = r_rdata;
    assign SelfWriteStrobe = (r_state == S_STROBE);
    assign SelfWriteData   = r_swdata;
    assign ComActive       = ~w_empty | (r_state != S_IDLE);
    assign irq             = r_irq_en & r_done;
endmodule

`default_nettype wire

// File: tb/tb_wb_fabric_config_port.sv
// ============================================================================
// Module      : tb_wb_fabric_config_port
// Description : Directed self-checking bench for wb_fabric_config_port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_fabric_config_port;
    localparam logic [31:0] A_DATA    = 32'h3000_0000;
    localparam logic [31:0] A_CTRL    = 32'h3000_0004;
    localparam logic [31:0] A_STATUS  = 32'h3000_0008;
    localparam logic [31:0] A_WORDCNT = 32'h3000_000C;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        SelfWriteStrobe;
    logic [31:0] SelfWriteData;
    logic        ComActive;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    logic [31:0] strobe_q[$];
    int          strobe_cyc[$];

    wb_fabric_config_port_if bus();

    wb_fabric_config_port dut (
        .CLK             (CLK),
        .resetn          (resetn),
        .wb              (bus),
        .SelfWriteStrobe (SelfWriteStrobe),
        .SelfWriteData   (SelfWriteData),
        .ComActive       (ComActive),
        .irq             (irq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    always @(negedge CLK) begin
        if (SelfWriteStrobe) begin
            strobe_q.push_back(SelfWriteData);
            strobe_cyc.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input int max_wait, output bit ok, output logic [31:0] rd);
        @(posedge CLK); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        ok = 1'b0;
        rd = 32'h0;
        for (int i = 0; i < max_wait; i++) begin
            @(posedge CLK); #1;
            if (bus.wbs_ack_o) begin
                ok = 1'b1;
                rd = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit ok;
        logic [31:0] rd;
        wb_cycle(adr, dat, sel, 1'b1, 40, ok, rd);
        check({tag, "_ack"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bit ok;
        logic [31:0] rd;
        wb_cycle(adr, 32'h0, 4'hF, 1'b0, 40, ok, rd);
        check({tag, "_ack"}, {31'b0, ok}, 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (strobe_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        bit          ok;
        logic [31:0] rd;
        int          base;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;

        // Reset values
        idle(3);
        check("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_strobe", {31'b0, SelfWriteStrobe}, 32'd0);
        check("rst_swdata", SelfWriteData, 32'd0);
        check("rst_active", {31'b0, ComActive}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge CLK) resetn = 1'b1;
        idle(2);
        rd_check("rst_status", A_STATUS, 32'h0000_0400);
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_wordcnt", A_WORDCNT, 32'h0);

        // Unselected addresses are never acked
        wb_cycle(32'h3000_0010, 32'h0, 4'hF, 1'b0, 4, ok, rd);
        check("unsel_ack", {31'b0, ok}, 32'd0);
        wb_cycle(32'h3100_0000, 32'h1, 4'hF, 1'b1, 4, ok, rd);
        check("unsel2_ack", {31'b0, ok}, 32'd0);

        // Basic stream
        base = strobe_q.size();
        for (int k = 0; k < 4; k++) wr("basic_push", A_DATA, 32'hA5A5_0001 + 32'(k), 4'hF);
        @(posedge CLK); #1;
        check("ack_single", {31'b0, bus.wbs_ack_o}, 32'd0);
        rd_check("basic_status4", A_STATUS, 32'h0000_0004);
        rd_check("data_reads0", A_DATA, 32'h0);
        check("basic_nostrobe", 32'(strobe_q.size() - base), 32'd0);
        wr("basic_en", A_CTRL, 32'h1, 4'hF);
        wait_strobes("basic_wait", base + 4, 40);
        idle(4);
        check("basic_count", 32'(strobe_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) check("basic_data", strobe_q[base + k], 32'hA5A5_0001 + 32'(k));
        for (int k = 1; k < 4; k++) check("basic_spacing", 32'(strobe_cyc[base + k] - strobe_cyc[base + k - 1]), 32'd2);
        check("basic_active", {31'b0, ComActive}, 32'd0);
        check("basic_irq", {31'b0, irq}, 32'd0);
        rd_check("basic_wordcnt", A_WORDCNT, 32'd4);
        rd_check("basic_status", A_STATUS, 32'h0000_1400);
        wr("st_clr", A_STATUS, 32'h0, 4'hF);
        rd_check("st_cleared", A_STATUS, 32'h0000_0400);
        wr("wc_clr", A_WORDCNT, 32'h1234, 4'hF);
        rd_check("wc_cleared", A_WORDCNT, 32'h0);

        // Byte-select error
        base = strobe_q.size();
        wr("selerr_wr", A_DATA, 32'hDEAD_BEEF, 4'h3);
        rd_check("selerr_status", A_STATUS, 32'h0000_0C00);
        check("selerr_nostrobe", 32'(strobe_q.size() - base), 32'd0);
        wr("selerr_clr", A_STATUS, 32'h0, 4'hF);
        rd_check("selerr_cleared", A_STATUS, 32'h0000_0400);

        // Backpressure
        wr("bp_dis", A_CTRL, 32'h0, 4'hF);
        base = strobe_q.size();
        for (int k = 0; k < 16; k++) wr("bp_push", A_DATA, 32'hB000_0000 + 32'(k), 4'hF);
        rd_check("bp_full", A_STATUS, 32'h0000_0210);
        wb_cycle(A_DATA, 32'hB000_0010, 4'hF, 1'b1, 6, ok, rd);
        check("bp_withheld", {31'b0, ok}, 32'd0);
        wr("bp_en", A_CTRL, 32'h1, 4'hF);
        wr("bp_push17", A_DATA, 32'hB000_0010, 4'hF);
        wait_strobes("bp_wait", base + 17, 120);
        idle(4);
        check("bp_count", 32'(strobe_q.size() - base), 32'd17);
        for (int k = 0; k < 17; k++) check("bp_data", strobe_q[base + k], 32'hB000_0000 + 32'(k));
        rd_check("bp_wordcnt", A_WORDCNT, 32'd17);
        rd_check("bp_status", A_STATUS, 32'h0000_1400);

        // Flush
        wr("fl_stclr", A_STATUS, 32'h0, 4'hF);
        wr("fl_dis", A_CTRL, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) wr("fl_push", A_DATA, 32'hF000_0000 + 32'(k), 4'hF);
        rd_check("fl_status5", A_STATUS, 32'h0000_0005);
        wr("fl_flush", A_CTRL, 32'h2, 4'hF);
        rd_check("fl_empty", A_STATUS, 32'h0000_0400);
        base = strobe_q.size();
        wr("fl_en", A_CTRL, 32'h1, 4'hF);
        idle(10);
        check("fl_nostrobe", 32'(strobe_q.size() - base), 32'd0);
        rd_check("fl_nodone", A_STATUS, 32'h0000_0400);
        rd_check("fl_ctrl", A_CTRL, 32'h1);

        // Interrupt
        wr("irq_en", A_CTRL, 32'h5, 4'hF);
        check("irq_low", {31'b0, irq}, 32'd0);
        base = strobe_q.size();
        wr("irq_push", A_DATA, 32'hC0DE_0001, 4'hF);
        wait_strobes("irq_wait", base + 1, 20);
        idle(4);
        check("irq_data", strobe_q[base], 32'hC0DE_0001);
        check("irq_high", {31'b0, irq}, 32'd1);
        wr("irq_sel0off", A_STATUS, 32'h0, 4'hE);
        check("irq_kept", {31'b0, irq}, 32'd1);
        wr("irq_clr", A_STATUS, 32'h0, 4'h1);
        @(posedge CLK); #1;
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // Reset during GAP
        wr("rm_dis", A_CTRL, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) wr("rm_push", A_DATA, 32'hE000_0000 + 32'(k), 4'hF);
        wr("rm_en", A_CTRL, 32'h1, 4'hF);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (SelfWriteStrobe) begin
                ok = 1'b1;
                break;
            end
        end
        check("rm_strobe_seen", {31'b0, ok}, 32'd1);
        @(posedge CLK); #1;
        check("rm_active_gap", {31'b0, ComActive}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rm_strobe", {31'b0, SelfWriteStrobe}, 32'd0);
        check("rm_swdata", SelfWriteData, 32'd0);
        check("rm_active", {31'b0, ComActive}, 32'd0);
        check("rm_irq", {31'b0, irq}, 32'd0);
        check("rm_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check("rm_dat", bus.wbs_dat_o, 32'd0);
        idle(2);
        @(negedge CLK) resetn = 1'b1;
        base = strobe_q.size();
        idle(10);
        check("rm_nostrobe", 32'(strobe_q.size() - base), 32'd0);
        check("rm_idle", {31'b0, ComActive}, 32'd0);
        rd_check("rm_status", A_STATUS, 32'h0000_0400);
        rd_check("rm_ctrl", A_CTRL, 32'h0);
        rd_check("rm_wordcnt", A_WORDCNT, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wb_fabric_config_port.md
Name: wb_fabric_config_port

Overview:
- Wishbone classic slave for the eFPGA configuration self-write port.
- The management core pushes 32-bit configuration words into a buffering FIFO. A drain FSM replays them onto SelfWriteStrobe/SelfWriteData with programmable spacing.
- Adds flush, status, a word counter and a completion interrupt.
- Sits in user_project_wrapper between the wbs_* bus and eFPGA_top, in place of the tied-off self-write inputs.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.
- STROBE_GAP, 1, idle cycles inserted after each SelfWriteStrobe pulse; 0..255.
- BASE_ADR, 32'h3000_0000, base address of the 4-register window (adr[3:2] selects the register).
- ADR_MASK, 32'hFFFF_FFF0, bits compared against BASE_ADR for decode.

Ports:
- CLK  in  1  system clock (wishbone and fabric config domain).
- resetn  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- SelfWriteStrobe  out  1  one-cycle config write pulse to the fabric.
- SelfWriteData  out  32  config word; valid while SelfWriteStrobe=1.
- ComActive  out  1  high while the FIFO is non-empty or the FSM is not IDLE.
- irq  out  1  completion interrupt (level).

Behaviour:
- Reset values: all outputs 0; FIFO empty; CTRL=0; WORDCNT=0; sticky bits 0; FSM=IDLE.

Register map (offset: function):
- 0x0 DATA, write-only. Pushes wbs_dat_i; reads return 0.
- 0x4 CTRL:
  - bit0 EN.
  - bit1 FLUSH: write-1, self-clearing, reads 0.
  - bit2 IRQ_EN.
- 0x8 STATUS, read-only:
  - [8:0] FIFO count.
  - bit9 full.
  - bit10 empty.
  - bit11 SELERR, sticky.
  - bit12 DONE, sticky.
  - Any write to STATUS clears bits 11 and 12.
- 0xC WORDCNT: count of words strobed to the fabric; wraps at 2^32; any write clears it to 0.

Wishbone handshake:
- A selected cycle is cyc&stb&(adr&ADR_MASK)==BASE_ADR.
- Registered ack: one cycle after a selected cycle is sampled, wbs_ack_o=1 for exactly one cycle, then 0 for at least one cycle (no back-to-back ack).
- Read data is valid in the ack cycle. Unselected cycles are never acked.
- DATA write while the FIFO is full: ack is withheld until a slot frees. A pop in the same cycle frees a slot, so the push is accepted that cycle.
- DATA write with sel!=4'hF: acked, data discarded, SELERR set.
- CTRL and STATUS writes honour sel[0] only.

Drain FSM (IDLE, STROBE, GAP):
- IDLE -> STROBE when EN=1 and FIFO non-empty. Pops the head, loads SelfWriteData, and drives SelfWriteStrobe=1 in the STROBE cycle.
- STROBE -> GAP when STROBE_GAP>0, otherwise back to IDLE. WORDCNT increments in STROBE.
- GAP counts STROBE_GAP cycles, then returns to IDLE.
- Peak rate is therefore one strobe per STROBE_GAP+1 cycles (one strobe every 2 cycles at the default), with pop-to-strobe latency of 1 cycle.
- SelfWriteData holds its value until the next pop.

EN, FLUSH and interrupt:
- EN cleared mid-stream: the current STROBE/GAP completes, then the FSM holds in IDLE and the FIFO is retained.
- FLUSH: the FIFO empties on the cycle after the write ack. An in-flight STROBE/GAP completes. WORDCNT is unaffected and DONE is not set.
- DONE is set when the FSM leaves STROBE or GAP into IDLE with the FIFO empty and EN=1.
- irq = IRQ_EN & DONE.
- Reset asserted mid-operation: everything returns to reset values immediately; no partial strobe is emitted after reset release.

Decomposition:
- Package fabric_cfg_pkg holds:
  - register offsets;
  - CTRL and STATUS bit positions;
  - the drain FSM state enum;
  - the DATA_W=32 constant.
- Sub-module cfg_fifo: synchronous FIFO parametrised by depth and width.
  - Ports: push, pop, din, dout, count, full, empty, flush.
  - Simultaneous push and pop is allowed at any fill level.

Test Plan:
- Reset mid-stream: assert resetn=0 during GAP -> all outputs 0 next sample; no strobe after release until re-enabled.
- Basic stream: write CTRL=0x1, then DATA 0xA5A5_0001..0xA5A5_0004 -> four strobes spaced 2 cycles apart, data in order. WORDCNT=4, DONE=1, ComActive falls after the last GAP.
- Backpressure: EN=0, push 17 words into the default 16-entry FIFO -> the 17th ack is withheld. Setting EN=1 -> 17th ack arrives one cycle after the first pop; all 17 words are strobed.
- Byte select: DATA write with sel=4'h3 -> ack given, FIFO count unchanged, STATUS bit11=1. Write STATUS -> bit11=0.
- Flush: EN=0, push 5 words, write CTRL=0x2 -> STATUS count=0 and empty=1. Setting EN=1 -> no strobe, DONE stays 0.
- Interrupt and wrap: IRQ_EN=1 with one word -> irq rises after its strobe, clears on STATUS write. Preload WORDCNT via 2^32-1 strobes in the formal or forced-state harness -> next strobe wraps WORDCNT to 0.
